image_pixel_packer: RTL and testbench
=====================================

IMAGE_PIXEL_PACKER -- requirements
Module: image_pixel_packer

Interface
REQ-001 SHALL have parameter LINE_MAX, default 2592, the maximum pixels per line counted; line_count and pixel counters are 12 bits.
REQ-002 SHALL have port pix_clk, input, 1: the single clock (sensor pixel clock); all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port capture_en, input, 1: arms capture of whole frames while high.
REQ-005 SHALL have port frame_valid, input, 1: sensor frame-valid.
REQ-006 SHALL have port line_valid, input, 1: sensor line-valid; a pixel is valid when frame_valid and line_valid are both high.
REQ-007 SHALL have port pix_data, input, 12: sensor pixel.
REQ-008 SHALL have port fifo_full, input, 1: downstream DDR2 write FIFO full.
REQ-009 SHALL have port fifo_wr_en, output, 1: one-cycle write strobe.
REQ-010 SHALL have port fifo_wr_data, output, 32: packed word.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse at the end of each captured frame.
REQ-012 SHALL have port line_count, output, 12: lines captured in the current or last frame.
REQ-013 SHALL have port overflow, output, 1: sticky flag, set when a word is dropped.
REQ-014 SHALL have port busy, output, 1: high in ARMED or CAPTURE.

Function
REQ-015 SHALL implement states IDLE, ARMED, CAPTURE.
REQ-016 IDLE -> ARMED when capture_en is high and frame_valid is low; if capture_en rises mid-frame, SHALL stay in IDLE until frame_valid is low, so no partial frame is captured.
REQ-017 ARMED -> CAPTURE on the cycle frame_valid is sampled high; capture_en low in ARMED returns the block to IDLE.
REQ-018 In CAPTURE, each valid pixel SHALL contribute pix_data[11:4] to a byte lane; lane order is pixel 0 in bits [7:0] through pixel 3 in bits [31:24].
REQ-019 After the 4th byte, SHALL assert fifo_wr_en with the word one cycle after the 4th pixel is sampled, giving a fixed latency of 1 cycle.
REQ-020 On a line_valid falling edge with 1-3 bytes pending, SHALL flush the partial word with zeros in the unused upper lanes, 1 cycle after the fall.
REQ-021 line_count SHALL increment on each line_valid falling edge in CAPTURE; it resets to 0 on entry to CAPTURE and saturates at 4095.
REQ-022 The pixel counter SHALL reset each line; pixels beyond LINE_MAX in one line SHALL be discarded without a write.
REQ-023 On a frame_valid falling edge in CAPTURE: SHALL complete any pending flush, pulse frame_done 1 cycle after the fall, then go to ARMED if capture_en is high, else to IDLE.
REQ-024 capture_en falling during CAPTURE SHALL NOT abort the frame; the frame completes per REQ-023.
REQ-025 If fifo_full is high on the cycle a write would occur, SHALL suppress fifo_wr_en, drop that word, and set overflow; packing SHALL continue with the next word.
REQ-026 overflow SHALL clear only on reset or on entry to CAPTURE with capture_en high.
REQ-027 A line edge and a frame edge falling on the same cycle SHALL count the line, flush once, then end the frame.

Reset
REQ-028 While reset is high, SHALL force: state IDLE, fifo_wr_en 0, fifo_wr_data 0, frame_done 0, line_count 0, overflow 0, busy 0, and clear all pack and pixel counters.
REQ-029 Reset asserted mid-frame SHALL discard pending bytes and emit no write; after release, the block SHALL follow REQ-016.

Configuration
REQ-030 Macro PACK16_EN: when defined, SHALL pack 2 pixels per word as zero-extended 12-bit values in bits [11:0] and [27:16], and flush after 1 pending pixel; when undefined, SHALL use 8-bit packing per REQ-018.

Verification
REQ-031 Frame of 2 lines x 8 pixels with values 0x010..0x080, capture_en high -> 4 writes; first write is 0x04030201; line_count 2; a single frame_done pulse.
REQ-032 capture_en raised mid-frame -> zero writes in that frame; the next full frame is captured completely.
REQ-033 Line of 6 pixels 0xFF0 -> writes 0xFFFFFFFF, then 0x0000FFFF one cycle after the line_valid fall.
REQ-034 fifo_full held for the 2nd word of a 16-pixel line -> 3 writes; overflow stays 1 until the next frame start.
REQ-035 Reset pulsed after 2 pixels of a line -> no write; all outputs 0; the next complete frame is captured correctly.
REQ-036 With PACK16_EN defined, pixels 0x123 and 0xABC -> write 0x0ABC0123.

Source files
------------

// File: rtl/image_pixel_packer.sv
// Packs sensor pixels into 32-bit words for a DDR2 write FIFO, capturing whole frames only.
// Optional macro PACK16_EN selects 2x12-bit packing instead of the default 4x8-bit packing.
module image_pixel_packer #(
  parameter int LINE_MAX = 2592
) (
  input  logic        pix_clk,
  input  logic        reset,
  input  logic        capture_en,
  input  logic        frame_valid,
  input  logic        line_valid,
  input  logic [11:0] pix_data,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_data,
  output logic        frame_done,
  output logic [11:0] line_count,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [11:0] LINE_MAX_C = 12'(LINE_MAX);
  localparam logic [11:0] LINE_SAT_C = 12'hFFF;

  state_t      state_r;
  state_t      state_nx_s;
  logic        lv_d_r;
  logic        fv_d_r;
  logic [31:0] pack_r;
  logic [1:0]  lane_cnt_r;
  logic [11:0] pix_cnt_r;
  logic [11:0] line_count_r;
  logic        overflow_r;
  logic        fifo_wr_en_r;
  logic [31:0] fifo_wr_data_r;
  logic        frame_done_r;
  logic        busy_r;

  logic        enter_cap_s;
  logic        pix_ok_s;
  logic        line_end_s;
  logic        frame_end_s;
  logic        full_s;
  logic        flush_s;
  logic        write_s;
  logic [31:0] word_s;
  logic [31:0] wr_word_s;
  logic [15:0] lane_val_s;
  logic [4:0]  lane_shift_s;
  logic [1:0]  last_lane_s;

`ifdef PACK16_EN
  assign lane_val_s   = {4'd0, pix_data};
  assign lane_shift_s = {lane_cnt_r[0], 4'd0};
  assign last_lane_s  = 2'd1;
`else
  logic pix_unused_s;
  assign pix_unused_s = ^pix_data[3:0];
  assign lane_val_s   = {8'd0, pix_data[11:4]};
  assign lane_shift_s = {lane_cnt_r, 3'd0};
  assign last_lane_s  = 2'd3;
`endif

  // State register
  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode and capture strobes
  always_comb begin
    state_nx_s  = state_r;
    enter_cap_s = 1'b0;
    pix_ok_s    = 1'b0;
    line_end_s  = 1'b0;
    frame_end_s = 1'b0;
    case (state_r)
      IDLE: begin
        // Waiting for frame_valid low guarantees we never start mid-frame.
        if (capture_en && !frame_valid) begin
          state_nx_s = ARMED;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ARMED: begin
        if (!capture_en) begin
          state_nx_s = IDLE;
        end else if (frame_valid) begin
          state_nx_s  = CAPTURE;
          enter_cap_s = 1'b1;
        end else begin
          state_nx_s = ARMED;
        end
      end
      CAPTURE: begin
        line_end_s  = lv_d_r && !line_valid;
        frame_end_s = fv_d_r && !frame_valid;
        pix_ok_s    = frame_valid && line_valid && (pix_cnt_r < LINE_MAX_C);
        if (frame_end_s) begin
          state_nx_s = capture_en ? ARMED : IDLE;
        end else begin
          state_nx_s = CAPTURE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Word assembly: a full word or a flush of the partial word, never both in one cycle
  always_comb begin
    word_s  = pack_r | ({16'd0, lane_val_s} << lane_shift_s);
    full_s  = pix_ok_s && (lane_cnt_r == last_lane_s);
    flush_s = (line_end_s || frame_end_s) && (lane_cnt_r != 2'd0);
    write_s = full_s || flush_s;
    if (full_s) begin
      wr_word_s = word_s;
    end else begin
      wr_word_s = pack_r;
    end
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      lv_d_r         <= 1'b0;
      fv_d_r         <= 1'b0;
      pack_r         <= 32'd0;
      lane_cnt_r     <= 2'd0;
      pix_cnt_r      <= 12'd0;
      line_count_r   <= 12'd0;
      overflow_r     <= 1'b0;
      fifo_wr_en_r   <= 1'b0;
      fifo_wr_data_r <= 32'd0;
      frame_done_r   <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      lv_d_r       <= line_valid;
      fv_d_r       <= frame_valid;
      frame_done_r <= frame_end_s;
      busy_r       <= (state_nx_s != IDLE);
      fifo_wr_en_r <= write_s && !fifo_full;

      if (write_s && !fifo_full) begin
        fifo_wr_data_r <= wr_word_s;
      end

      if (enter_cap_s && capture_en) begin
        overflow_r <= 1'b0;
      end else if (write_s && fifo_full) begin
        overflow_r <= 1'b1;
      end

      // A dropped word still empties the packer so the next word starts clean.
      if (enter_cap_s || write_s) begin
        pack_r     <= 32'd0;
        lane_cnt_r <= 2'd0;
      end else if (pix_ok_s) begin
        pack_r     <= word_s;
        lane_cnt_r <= lane_cnt_r + 2'd1;
      end

      if (enter_cap_s || line_end_s) begin
        pix_cnt_r <= 12'd0;
      end else if (pix_ok_s) begin
        pix_cnt_r <= pix_cnt_r + 12'd1;
      end

      if (enter_cap_s) begin
        line_count_r <= 12'd0;
      end else if (line_end_s && (line_count_r != LINE_SAT_C)) begin
        line_count_r <= line_count_r + 12'd1;
      end
    end
  end

  assign fifo_wr_en   = fifo_wr_en_r;
  assign fifo_wr_data = fifo_wr_data_r;
  assign frame_done   = frame_done_r;
  assign line_count   = line_count_r;
  assign overflow     = overflow_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_image_pixel_packer.sv
// Directed self-checking bench for image_pixel_packer; expected words are hand-computed.
module tb_image_pixel_packer;

  logic        pix_clk = 1'b0;
  logic        reset;
  logic        capture_en;
  logic        frame_valid;
  logic        line_valid;
  logic [11:0] pix_data;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        frame_done;
  logic [11:0] line_count;
  logic        overflow;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          fd_cnt   = 0;
  int          q_base   = 0;
  int          fd_base  = 0;
  logic [31:0] wr_q[$];

  image_pixel_packer dut (
    .pix_clk      (pix_clk),
    .reset        (reset),
    .capture_en   (capture_en),
    .frame_valid  (frame_valid),
    .line_valid   (line_valid),
    .pix_data     (pix_data),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .frame_done   (frame_done),
    .line_count   (line_count),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 pix_clk = ~pix_clk;

  // Write and frame_done log, sampled on the falling edge
  always @(negedge pix_clk) begin
    if (fifo_wr_en === 1'b1) wr_q.push_back(fifo_wr_data);
    if (frame_done === 1'b1) fd_cnt++;
  end

  function automatic logic [31:0] n_wr();
    return 32'(wr_q.size() - q_base);
  endfunction

  function automatic logic [31:0] wr_at(input int k);
    return wr_q[q_base + k];
  endfunction

  function automatic logic [31:0] n_fd();
    return 32'(fd_cnt - fd_base);
  endfunction

  task automatic mark();
    q_base  = wr_q.size();
    fd_base = fd_cnt;
  endtask

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    frame_valid = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_frame();
    line_valid  = 1'b0;
    frame_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_line(input int n, input logic [11:0] first, input logic [11:0] inc);
    for (int i = 0; i < n; i++) begin
      line_valid = 1'b1;
      pix_data   = first + 12'(i) * inc;
      tick();
    end
    line_valid = 1'b0;
    pix_data   = 12'd0;
    tick();
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    capture_en  = 1'b0;
    frame_valid = 1'b0;
    line_valid  = 1'b0;
    pix_data    = 12'd0;
    fifo_full   = 1'b0;
    repeat (3) tick();
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_data", fifo_wr_data, 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_line_count", 32'(line_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

`ifdef PACK16_EN
    capture_en = 1'b1;
    tick();
    mark();
    start_frame();
    line_valid = 1'b1; pix_data = 12'h123; tick();
    line_valid = 1'b1; pix_data = 12'hABC; tick();
    chk("p16_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("p16_word", fifo_wr_data, 32'h0ABC0123);
    line_valid = 1'b1; pix_data = 12'h456; tick();
    line_valid = 1'b0; pix_data = 12'd0; tick();
    chk("p16_flush_en", 32'(fifo_wr_en), 32'd1);
    chk("p16_flush", fifo_wr_data, 32'h00000456);
    tick();
    end_frame();
    chk("p16_writes", n_wr(), 32'd2);
    chk("p16_frames", n_fd(), 32'd1);
`else
    // Two lines of eight pixels
    capture_en = 1'b1;
    tick();
    chk("arm_busy", 32'(busy), 32'd1);
    mark();
    start_frame();
    for (int i = 0; i < 8; i++) begin
      line_valid = 1'b1;
      pix_data   = 12'h010 * 12'(i + 1);
      tick();
      if (i == 3) begin
        chk("lat_wr_en", 32'(fifo_wr_en), 32'd1);
        chk("lat_word", fifo_wr_data, 32'h04030201);
      end
    end
    line_valid = 1'b0;
    tick();
    tick();
    send_line(8, 12'h010, 12'h010);
    frame_valid = 1'b0;
    tick();
    chk("f1_frame_done", 32'(frame_done), 32'd1);
    chk("f1_line_count", 32'(line_count), 32'd2);
    tick();
    chk("f1_done_pulse", 32'(frame_done), 32'd0);
    chk("f1_writes", n_wr(), 32'd4);
    chk("f1_w0", wr_at(0), 32'h04030201);
    chk("f1_w1", wr_at(1), 32'h08070605);
    chk("f1_w3", wr_at(3), 32'h08070605);
    chk("f1_frames", n_fd(), 32'd1);

    // capture_en raised mid-frame: that frame is skipped
    capture_en = 1'b0;
    tick();
    chk("disarm_busy", 32'(busy), 32'd0);
    mark();
    frame_valid = 1'b1;
    tick();
    capture_en = 1'b1;
    tick();
    chk("mid_busy", 32'(busy), 32'd0);
    send_line(8, 12'h010, 12'h010);
    end_frame();
    chk("mid_writes", n_wr(), 32'd0);
    chk("mid_frames", n_fd(), 32'd0);
    mark();
    start_frame();
    send_line(8, 12'h100, 12'h010);
    end_frame();
    chk("next_writes", n_wr(), 32'd2);
    chk("next_w0", wr_at(0), 32'h13121110);
    chk("next_w1", wr_at(1), 32'h17161514);
    chk("next_lines", 32'(line_count), 32'd1);

    // Six pixels: one full word then a partial flush
    mark();
    start_frame();
    for (int i = 0; i < 6; i++) begin
      line_valid = 1'b1;
      pix_data   = 12'hFF0;
      tick();
    end
    chk("six_no_early", 32'(fifo_wr_en), 32'd0);
    line_valid = 1'b0;
    tick();
    chk("six_flush_en", 32'(fifo_wr_en), 32'd1);
    chk("six_flush", fifo_wr_data, 32'h0000FFFF);
    tick();
    end_frame();
    chk("six_writes", n_wr(), 32'd2);
    chk("six_w0", wr_at(0), 32'hFFFFFFFF);

    // fifo_full during the second word of a 16-pixel line
    chk("ovf_before", 32'(overflow), 32'd0);
    mark();
    start_frame();
    for (int i = 0; i < 16; i++) begin
      line_valid = 1'b1;
      pix_data   = 12'h010 * 12'(i + 1);
      fifo_full  = (i >= 4) && (i <= 7);
      tick();
    end
    fifo_full  = 1'b0;
    line_valid = 1'b0;
    tick();
    tick();
    end_frame();
    chk("ovf_writes", n_wr(), 32'd3);
    chk("ovf_w0", wr_at(0), 32'h04030201);
    chk("ovf_w1", wr_at(1), 32'h0C0B0A09);
    chk("ovf_w2", wr_at(2), 32'h100F0E0D);
    repeat (3) tick();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset after two pixels of a line
    mark();
    start_frame();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    line_valid = 1'b1; pix_data = 12'h010; tick();
    line_valid = 1'b1; pix_data = 12'h020; tick();
    reset = 1'b1;
    tick();
    chk("mrst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("mrst_wr_data", fifo_wr_data, 32'd0);
    chk("mrst_line_count", 32'(line_count), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    reset      = 1'b0;
    line_valid = 1'b0;
    tick();
    tick();
    chk("mrst_idle", 32'(busy), 32'd0);
    frame_valid = 1'b0;
    tick();
    chk("mrst_rearm", 32'(busy), 32'd1);
    chk("mrst_no_write", n_wr(), 32'd0);
    start_frame();
    send_line(8, 12'h010, 12'h010);
    end_frame();
    chk("mrst_writes", n_wr(), 32'd2);
    chk("mrst_w0", wr_at(0), 32'h04030201);
    chk("mrst_frames", n_fd(), 32'd1);

    // Pixels past LINE_MAX are discarded
    mark();
    start_frame();
    send_line(2594, 12'h550, 12'h000);
    end_frame();
    chk("lmax_writes", n_wr(), 32'd648);
    chk("lmax_last", wr_at(647), 32'h55555555);

    // line_count saturation
    mark();
    start_frame();
    for (int i = 0; i < 4097; i++) begin
      line_valid = 1'b1;
      pix_data   = 12'h000;
      tick();
      line_valid = 1'b0;
      tick();
    end
    end_frame();
    chk("sat_line_count", 32'(line_count), 32'd4095);
    chk("sat_writes", n_wr(), 32'd4097);

    // Line and frame fall together; capture_en dropped mid-frame
    mark();
    start_frame();
    for (int i = 0; i < 5; i++) begin
      line_valid = 1'b1;
      pix_data   = 12'h210 + 12'h010 * 12'(i);
      if (i == 2) capture_en = 1'b0;
      tick();
    end
    line_valid  = 1'b0;
    frame_valid = 1'b0;
    tick();
    chk("both_flush_en", 32'(fifo_wr_en), 32'd1);
    chk("both_flush", fifo_wr_data, 32'h00000025);
    chk("both_frame_done", 32'(frame_done), 32'd1);
    chk("both_line_count", 32'(line_count), 32'd1);
    tick();
    chk("both_idle", 32'(busy), 32'd0);
    chk("both_writes", n_wr(), 32'd2);
    chk("both_w0", wr_at(0), 32'h24232221);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
